// File: rtl/eaglesong_absorb_if.sv
// ============================================================================
// Module  : eaglesong_absorb_if
// Brief   : Message stream, permutation link and squeeze-side bundle
//           used by the Eaglesong absorb controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface eaglesong_absorb_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_data;
    logic        msg_last;
    logic [2:0]  msg_nbytes;

    logic        perm_start;
    logic [31:0] perm_state_in  [16];
    logic [31:0] perm_state_out [16];
    logic        perm_done;

    logic [31:0] state_out [16];
    logic        state_valid;
    logic        state_ready;

    modport slave (
        input  msg_valid, msg_data, msg_last, msg_nbytes,
        input  perm_state_out, perm_done, state_ready,
        output msg_ready, perm_start, perm_state_in, state_out, state_valid
    );

    modport master (
        output msg_valid, msg_data, msg_last, msg_nbytes,
        output perm_state_out, perm_done, state_ready,
        input  msg_ready, perm_start, perm_state_in, state_out, state_valid
    );
endinterface

`default_nettype wire

// File: rtl/eaglesong_absorb.sv
// ============================================================================
// Module  : eaglesong_absorb
// Brief   : Sponge absorb controller: pads the message, XORs rate blocks
//           into the 16-word state and sequences the permutation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module eaglesong_absorb #(
    parameter int         RATE_WORDS = 8,
    parameter logic [7:0] DELIM      = 8'h06
) (
    input  logic               clk,
    input  logic               rst,
    eaglesong_absorb_if.slave  bus
);

    localparam logic [3:0] c_LAST_WORD = 4'(RATE_WORDS - 1);

    typedef enum logic [2:0] {
        S_ACCEPT = 3'd0,
        S_PAD    = 3'd1,
        S_PSTART = 3'd2,
        S_PWAIT  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t      r_fsm;
    state_t      w_fsm_nxt;
    logic [31:0] r_state [16];
    logic [3:0]  r_wcnt;
    logic        r_pad_pending;
    logic        r_final;

    logic        w_ready;
    logic        w_perm_start;
    logic        w_state_valid;
    logic        w_fire;
    logic        w_full;
    logic        w_last_short;
    logic [31:0] w_word;

    // Ready is gated by rst so no word is accepted during the reset cycle.
    assign bus.msg_ready   = w_ready & ~rst;
    assign bus.perm_start  = w_perm_start;
    assign bus.state_valid = w_state_valid;

    assign w_fire       = bus.msg_valid & bus.msg_ready;
    assign w_full       = (r_wcnt == c_LAST_WORD);
    assign w_last_short = bus.msg_last & ~bus.msg_nbytes[2];

    for (genvar gi = 0; gi < 16; gi++) begin : g_state_copy
        assign bus.perm_state_in[gi] = r_state[gi];
        assign bus.state_out[gi]     = r_state[gi];
    end

    // Short last word: keep the valid bytes, drop in the delimiter, zero the rest.
    always_comb begin
        w_word = bus.msg_data;
        if (w_last_short) begin
            case (bus.msg_nbytes[1:0])
                2'd0:    w_word = {DELIM, 24'h0};
                2'd1:    w_word = {bus.msg_data[31:24], DELIM, 16'h0};
                2'd2:    w_word = {bus.msg_data[31:16], DELIM, 8'h0};
                default: w_word = {bus.msg_data[31:8], DELIM};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_ACCEPT;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_ready       = 1'b0;
        w_perm_start  = 1'b0;
        w_state_valid = 1'b0;
        case (r_fsm)
            S_ACCEPT: begin
                w_ready = 1'b1;
                if (w_fire) begin
                    if (w_last_short || w_full) begin
                        w_fsm_nxt = S_PSTART;
                    end else if (bus.msg_last) begin
                        w_fsm_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                w_fsm_nxt = S_PSTART;
            end
            S_PSTART: begin
                w_perm_start = 1'b1;
                w_fsm_nxt    = S_PWAIT;
            end
            S_PWAIT: begin
                if (bus.perm_done) begin
                    if (r_final) begin
                        w_fsm_nxt = S_HOLD;
                    end else if (r_pad_pending) begin
                        w_fsm_nxt = S_PAD;
                    end else begin
                        w_fsm_nxt = S_ACCEPT;
                    end
                end
            end
            S_HOLD: begin
                w_state_valid = 1'b1;
                if (bus.state_ready) begin
                    w_fsm_nxt = S_ACCEPT;
                end
            end
            default: begin
                w_fsm_nxt = S_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_state[i] <= 32'h0;
            end
            r_wcnt        <= 4'd0;
            r_pad_pending <= 1'b0;
            r_final       <= 1'b0;
        end else begin
            case (r_fsm)
                S_ACCEPT: begin
                    if (w_fire) begin
                        r_state[r_wcnt] <= r_state[r_wcnt] ^ w_word;
                        if (w_last_short || w_full) begin
                            r_wcnt <= 4'd0;
                        end else begin
                            r_wcnt <= r_wcnt + 4'd1;
                        end
                        if (w_last_short) begin
                            r_final <= 1'b1;
                        end else if (w_full) begin
                            r_final <= 1'b0;
                        end
                        // A full last word still owes a delimiter-only pad step.
                        if (bus.msg_last && !w_last_short) begin
                            r_pad_pending <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    r_state[r_wcnt] <= r_state[r_wcnt] ^ {DELIM, 24'h0};
                    r_pad_pending   <= 1'b0;
                    r_wcnt          <= 4'd0;
                    r_final         <= 1'b1;
                end
                S_PWAIT: begin
                    if (bus.perm_done) begin
                        for (int i = 0; i < 16; i++) begin
                            r_state[i] <= bus.perm_state_out[i];
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.state_ready) begin
                        for (int i = 0; i < 16; i++) begin
                            r_state[i] <= 32'h0;
                        end
                        r_final <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eaglesong_absorb.sv
// ============================================================================
// Module  : tb_eaglesong_absorb
// Brief   : Directed self-checking bench for eaglesong_absorb with a toy
//           permutation (word 15 ^= A5A5A5A5, done three cycles later).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_eaglesong_absorb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eaglesong_absorb_if bus ();

    eaglesong_absorb #(
        .RATE_WORDS (8),
        .DELIM      (8'h06)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_calls  = 0;
    int          pend     = 0;
    int          start_cyc [8];
    logic [31:0] snap      [8][16];
    logic [31:0] res       [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] or_words(input logic [31:0] a [16], input int from);
        logic [31:0] acc = 32'h0;
        for (int i = from; i < 16; i++) acc |= a[i];
        return acc;
    endfunction

    // Permutation model, driven on the falling edge.
    initial begin
        bus.perm_done = 1'b0;
        for (int i = 0; i < 16; i++) bus.perm_state_out[i] = 32'h0;
        forever begin
            @(negedge clk);
            bus.perm_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    for (int i = 0; i < 16; i++) bus.perm_state_out[i] = res[i];
                    bus.perm_done = 1'b1;
                end
            end
            if (bus.perm_start) begin
                if (n_calls < 8) begin
                    start_cyc[n_calls] = cyc;
                    for (int i = 0; i < 16; i++) snap[n_calls][i] = bus.perm_state_in[i];
                end
                for (int i = 0; i < 16; i++) res[i] = bus.perm_state_in[i];
                res[15] = res[15] ^ 32'hA5A5A5A5;
                n_calls++;
                pend = 3;
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] n, output int h);
        int t = 0;
        @(negedge clk);
        if (!bus.msg_ready) begin
            bus.msg_valid = 1'b0;
            while (!bus.msg_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!bus.msg_ready) check_val("send_timeout", 32'd0, 32'd1);
        end
        bus.msg_valid  = 1'b1;
        bus.msg_data   = d;
        bus.msg_last   = last;
        bus.msg_nbytes = n;
        h = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_data  = 32'hFFFFFFFF;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!bus.state_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val(tag, 32'(bus.state_valid), 32'd1);
    endtask

    task automatic release_state(input string tag);
        @(negedge clk);
        bus.state_ready = 1'b1;
        @(negedge clk);
        bus.state_ready = 1'b0;
        check_val({tag, "_cleared"}, or_words(bus.state_out, 0), 32'h0);
        check_val({tag, "_ready"}, 32'(bus.msg_ready), 32'd1);
    endtask

    initial begin
        int          h;
        int          base;
        int          bad;
        int          t;
        logic [31:0] keep [16];

        rst             = 1'b1;
        bus.msg_valid   = 1'b0;
        bus.msg_data    = 32'h0;
        bus.msg_last    = 1'b0;
        bus.msg_nbytes  = 3'd0;
        bus.state_ready = 1'b0;

        @(negedge clk);
        check_val("rst_msg_ready", 32'(bus.msg_ready), 32'd0);
        check_val("rst_perm_start", 32'(bus.perm_start), 32'd0);
        check_val("rst_state_valid", 32'(bus.state_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", 32'(bus.msg_ready), 32'd1);
        check_val("post_rst_state", or_words(bus.state_out, 0), 32'h0);

        // Empty message; garbage data bytes must not leak in.
        base = n_calls;
        send_word(32'hFFFFFFFF, 1'b1, 3'd0, h);
        idle();
        wait_valid("empty_valid");
        check_val("empty_calls", 32'(n_calls - base), 32'd1);
        check_val("empty_in0", snap[base][0], 32'h06000000);
        check_val("empty_in_rest", or_words(snap[base], 1), 32'h0);
        check_val("empty_out15", bus.state_out[15], 32'hA5A5A5A5);
        check_val("empty_out0", bus.state_out[0], 32'h06000000);
        release_state("empty");

        // Full single word: a PAD cycle sits between handshake and start.
        base = n_calls;
        send_word(32'h61626364, 1'b1, 3'd4, h);
        idle();
        wait_valid("w4_valid");
        check_val("w4_calls", 32'(n_calls - base), 32'd1);
        check_val("w4_latency", 32'(start_cyc[base] - h), 32'd2);
        check_val("w4_in0", snap[base][0], 32'h61626364);
        check_val("w4_in1", snap[base][1], 32'h06000000);
        release_state("w4");

        // Three-byte last word: delimiter in byte 3, no PAD cycle.
        base = n_calls;
        send_word(32'hDEADBEEF, 1'b1, 3'd3, h);
        idle();
        wait_valid("w3_valid");
        check_val("w3_calls", 32'(n_calls - base), 32'd1);
        check_val("w3_latency", 32'(start_cyc[base] - h), 32'd1);
        check_val("w3_in0", snap[base][0], 32'hDEADBE06);
        release_state("w3");

        // Exactly one full block: second call carries only the delimiter.
        base = n_calls;
        for (int i = 1; i <= 8; i++) begin
            send_word(32'h01010101 * i, (i == 8), 3'd4, h);
        end
        idle();
        wait_valid("blk_valid");
        check_val("blk_calls", 32'(n_calls - base), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("blk_in%0d", i), snap[base][i], 32'h01010101 * (i + 1));
        end
        // Delimiter lands on top of the permuted word 0 (0x01010101).
        check_val("blk2_in0", snap[base + 1][0], 32'h07010101);
        check_val("blk2_in15", snap[base + 1][15], 32'hA5A5A5A5);
        check_val("blk_out15", bus.state_out[15], 32'h0);

        // Downstream stall in HOLD.
        for (int i = 0; i < 16; i++) keep[i] = bus.state_out[i];
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) if (bus.state_out[i] !== keep[i]) bad++;
            if (bus.msg_ready !== 1'b0 || bus.state_valid !== 1'b1) bad++;
        end
        check_val("hold_stable", 32'(bad), 32'd0);
        release_state("hold");

        // Reset while waiting on the permutation; its done arrives late.
        base = n_calls;
        send_word(32'hAABBCCDD, 1'b1, 3'd2, h);
        idle();
        t = 0;
        while (n_calls == base && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("prst_started", 32'(n_calls - base), 32'd1);
        check_val("prst_in0", snap[base][0], 32'hAABB0600);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("prst_ready_in_rst", 32'(bus.msg_ready), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("prst_no_start", 32'(n_calls - base), 32'd1);
        check_val("prst_valid", 32'(bus.state_valid), 32'd0);
        check_val("prst_ready", 32'(bus.msg_ready), 32'd1);
        check_val("prst_state", or_words(bus.state_out, 0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
